// File: rtl/bsg_clk_mon_multi.sv
// Multi-channel clock frequency monitor: counts synchronised rising edges of each
// monitored clock over a programmable gate window and reports counts with range/overflow flags.
module bsg_clk_mon_multi #(
    parameter int num_channels_p = 4,
    parameter int count_width_p  = 16,
    parameter int window_width_p = 16,
    parameter int sync_stages_p  = 2
) (
    input  logic                                    clk_i,
    input  logic                                    async_reset_n_i,
    input  logic [num_channels_p-1:0]               mon_clk_i,
    input  logic                                    cfg_v_i,
    output logic                                    cfg_ready_o,
    input  logic [window_width_p-1:0]               cfg_window_i,
    input  logic [num_channels_p-1:0]               cfg_mask_i,
    input  logic [count_width_p-1:0]                cfg_lo_i,
    input  logic [count_width_p-1:0]                cfg_hi_i,
    input  logic                                    cfg_continuous_i,
    input  logic                                    abort_i,
    output logic                                    busy_o,
    output logic                                    v_o,
    output logic [num_channels_p*count_width_p-1:0] count_o,
    output logic [num_channels_p-1:0]               out_of_range_o,
    output logic [num_channels_p-1:0]               overflow_o,
    input  logic                                    yumi_i
);

    localparam int arm_width_lp = $clog2(sync_stages_p);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_e;

    state_e                       state_r;
    logic [window_width_p-1:0]    win_r;
    logic [window_width_p-1:0]    win_cnt_r;
    logic [num_channels_p-1:0]    mask_r;
    logic [count_width_p-1:0]     lo_r;
    logic [count_width_p-1:0]     hi_r;
    logic                         cont_r;
    logic [arm_width_lp-1:0]      arm_cnt_r;

    logic [sync_stages_p-1:0]     sync_r [num_channels_p];
    logic [num_channels_p-1:0]    prev_r;
    logic [num_channels_p-1:0]    edge_w;

    logic [count_width_p-1:0]     cnt_r [num_channels_p];
    logic [count_width_p-1:0]     cnt_n [num_channels_p];
    logic [num_channels_p-1:0]    ovf_r;
    logic [num_channels_p-1:0]    ovf_n;
    logic [num_channels_p-1:0]    oor_n;

    assign cfg_ready_o = (state_r == IDLE);
    assign busy_o      = (state_r != IDLE);

    // Synchronisers and edge history run in every state so ARM can flush stale edges.
    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            for (int unsigned c = 0; c < num_channels_p; c++) begin
                sync_r[c] <= '0;
            end
            prev_r <= '0;
        end else begin
            for (int unsigned c = 0; c < num_channels_p; c++) begin
                sync_r[c] <= {sync_r[c][sync_stages_p-2:0], mon_clk_i[c]};
                prev_r[c] <= sync_r[c][sync_stages_p-1];
            end
        end
    end

    always_comb begin
        edge_w = '0;
        ovf_n  = ovf_r;
        oor_n  = '0;
        for (int unsigned c = 0; c < num_channels_p; c++) begin
            edge_w[c] = sync_r[c][sync_stages_p-1] & ~prev_r[c];
            cnt_n[c]  = cnt_r[c];
            if (mask_r[c] && edge_w[c]) begin
                if (cnt_r[c] == '1) begin
                    ovf_n[c] = 1'b1;
                end else begin
                    cnt_n[c] = cnt_r[c] + count_width_p'(1);
                end
            end
            oor_n[c] = mask_r[c] && ((cnt_n[c] < lo_r) || (cnt_n[c] > hi_r));
        end
    end

    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            state_r        <= IDLE;
            win_r          <= '0;
            win_cnt_r      <= '0;
            mask_r         <= '0;
            lo_r           <= '0;
            hi_r           <= '0;
            cont_r         <= 1'b0;
            arm_cnt_r      <= '0;
            ovf_r          <= '0;
            v_o            <= 1'b0;
            count_o        <= '0;
            out_of_range_o <= '0;
            overflow_o     <= '0;
            for (int unsigned c = 0; c < num_channels_p; c++) begin
                cnt_r[c] <= '0;
            end
        end else if (abort_i) begin
            state_r <= IDLE;
            v_o     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cfg_v_i) begin
                        win_r     <= (cfg_window_i == '0) ? window_width_p'(1) : cfg_window_i;
                        mask_r    <= cfg_mask_i;
                        lo_r      <= cfg_lo_i;
                        hi_r      <= cfg_hi_i;
                        cont_r    <= cfg_continuous_i;
                        arm_cnt_r <= '0;
                        state_r   <= ARM;
                    end
                end
                ARM: begin
                    if (arm_cnt_r == arm_width_lp'(sync_stages_p - 1)) begin
                        win_cnt_r <= '0;
                        ovf_r     <= '0;
                        for (int unsigned c = 0; c < num_channels_p; c++) begin
                            cnt_r[c] <= '0;
                        end
                        state_r <= MEASURE;
                    end else begin
                        arm_cnt_r <= arm_cnt_r + arm_width_lp'(1);
                    end
                end
                MEASURE: begin
                    ovf_r     <= ovf_n;
                    win_cnt_r <= win_cnt_r + window_width_p'(1);
                    for (int unsigned c = 0; c < num_channels_p; c++) begin
                        cnt_r[c] <= cnt_n[c];
                    end
                    // The last window cycle's edges are folded straight into the result.
                    if (win_cnt_r == win_r - window_width_p'(1)) begin
                        state_r        <= DONE;
                        v_o            <= 1'b1;
                        overflow_o     <= ovf_n;
                        out_of_range_o <= oor_n;
                        for (int unsigned c = 0; c < num_channels_p; c++) begin
                            count_o[c*count_width_p +: count_width_p] <= cnt_n[c];
                        end
                    end
                end
                DONE: begin
                    if (yumi_i) begin
                        v_o <= 1'b0;
                        if (cont_r) begin
                            arm_cnt_r <= '0;
                            state_r   <= ARM;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_clk_mon_multi.sv
// Directed self-checking bench for bsg_clk_mon_multi (4 channels, 8-bit counters, S=2).
module tb_bsg_clk_mon_multi;

    localparam int S = 2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  mon_clk;
    logic        cfg_v;
    logic        cfg_ready;
    logic [15:0] cfg_window;
    logic [3:0]  cfg_mask;
    logic [7:0]  cfg_lo;
    logic [7:0]  cfg_hi;
    logic        cfg_cont;
    logic        abort;
    logic        busy;
    logic        v;
    logic [31:0] count;
    logic [3:0]  oor;
    logic [3:0]  ovf;
    logic        yumi;

    int checks = 0;
    int errors = 0;
    int mon_half [4];

    bsg_clk_mon_multi #(
        .num_channels_p(4),
        .count_width_p (8),
        .window_width_p(16),
        .sync_stages_p (S)
    ) dut (
        .clk_i           (clk),
        .async_reset_n_i (rst_n),
        .mon_clk_i       (mon_clk),
        .cfg_v_i         (cfg_v),
        .cfg_ready_o     (cfg_ready),
        .cfg_window_i    (cfg_window),
        .cfg_mask_i      (cfg_mask),
        .cfg_lo_i        (cfg_lo),
        .cfg_hi_i        (cfg_hi),
        .cfg_continuous_i(cfg_cont),
        .abort_i         (abort),
        .busy_o          (busy),
        .v_o             (v),
        .count_o         (count),
        .out_of_range_o  (oor),
        .overflow_o      (ovf),
        .yumi_i          (yumi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitored clocks toggle at 3 mod 5 time units, never on a clk edge; half=0 holds low.
    for (genvar g = 0; g < 4; g++) begin : g_mon
        logic m;
        initial begin
            m = 1'b0;
            #3;
            forever begin
                if (mon_half[g] == 0) begin
                    m = 1'b0;
                    #10;
                end else begin
                    #(mon_half[g]) m = ~m;
                end
            end
        end
        assign mon_clk[g] = m;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
        checks++;
        assert (((obs >= 32'(lo)) && (obs <= 32'(hi))) === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic logic [7:0] chan(input int c);
        return count[c*8 +: 8];
    endfunction

    // Called at a negedge; the following posedge is the acceptance edge.
    task automatic do_cfg(input logic [15:0] w, input logic [3:0] mask,
                          input logic [7:0] lo, input logic [7:0] hi, input logic cont);
        cfg_v = 1'b1; cfg_window = w; cfg_mask = mask; cfg_lo = lo; cfg_hi = hi; cfg_cont = cont;
        @(posedge clk);
        @(negedge clk);
        cfg_v = 1'b0;
    endtask

    task automatic wait_v(input int max, output int n);
        n = 0;
        while (v !== 1'b1 && n < max) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_yumi();
        yumi = 1'b1;
        @(posedge clk);
        @(negedge clk);
        yumi = 1'b0;
    endtask

    initial begin
        int n;
        logic ok;
        rst_n = 1'b0; cfg_v = 1'b0; cfg_window = '0; cfg_mask = '0; cfg_lo = '0;
        cfg_hi = '0; cfg_cont = 1'b0; abort = 1'b0; yumi = 1'b0;
        mon_half[0] = 20; mon_half[1] = 30; mon_half[2] = 40; mon_half[3] = 50;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_v", 32'(v), 0);
        check("rst_count", count, 0);
        check("rst_flags", {24'd0, oor, ovf}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single shot: periods 4,6,8,10 over W=120
        do_cfg(16'd120, 4'b1111, 8'd10, 8'd25, 1'b0);
        check("s1_busy", 32'(busy), 1);
        check("s1_ready", 32'(cfg_ready), 0);
        wait_v(200, n);
        check("s1_latency", n, 122);
        check_rng("s1_ch0", 32'(chan(0)), 29, 31);
        check_rng("s1_ch1", 32'(chan(1)), 19, 21);
        check_rng("s1_ch2", 32'(chan(2)), 14, 16);
        check_rng("s1_ch3", 32'(chan(3)), 11, 13);
        check("s1_oor", 32'(oor), 32'h1);
        check("s1_ovf", 32'(ovf), 0);
        pulse_yumi();
        check("s1_v_after_yumi", 32'(v), 0);
        check("s1_idle", 32'(busy), 0);
        check("s1_oor_held", 32'(oor), 32'h1);

        // Mask and saturation: period 3 on all channels, W=1000
        for (int i = 0; i < 4; i++) mon_half[i] = 15;
        repeat (4) @(negedge clk);
        do_cfg(16'd1000, 4'b1010, 8'd0, 8'd255, 1'b0);
        wait_v(1100, n);
        check("sat_latency", n, 1002);
        check("sat_count", count, 32'hFF00FF00);
        check("sat_ovf", 32'(ovf), 32'hA);
        check("sat_oor", 32'(oor), 0);
        pulse_yumi();

        // Continuous mode with yumi delayed 50 cycles, 3 re-arms
        for (int i = 0; i < 4; i++) mon_half[i] = 20;
        repeat (4) @(negedge clk);
        do_cfg(16'd40, 4'b1111, 8'd0, 8'd255, 1'b1);
        wait_v(100, n);
        check("cont_first_latency", n, S + 40);
        for (int it = 0; it < 3; it++) begin
            ok = 1'b1;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (v !== 1'b1) ok = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    if (chan(c) < 8'd9 || chan(c) > 8'd11) ok = 1'b0;
                end
            end
            check("cont_hold", 32'(ok), 1);
            pulse_yumi();
            check("cont_v_drop", 32'(v), 0);
            check("cont_rearm_busy", 32'(busy), 1);
            wait_v(100, n);
            check("cont_latency", n, S + 40);
        end
        // abort wins over yumi in DONE even in continuous mode
        abort = 1'b1; yumi = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0; yumi = 1'b0;
        check("cont_abort_busy", 32'(busy), 0);
        check("cont_abort_v", 32'(v), 0);

        // abort wins over cfg acceptance in IDLE
        cfg_v = 1'b1; abort = 1'b1; cfg_window = 16'd5; cfg_mask = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cfg_v = 1'b0; abort = 1'b0;
        check("idle_abort_cfg", 32'(busy), 0);

        // Abort mid-MEASURE, then new cfg in the first IDLE cycle
        do_cfg(16'd200, 4'b0001, 8'd0, 8'd255, 1'b0);
        repeat (20) @(negedge clk);
        check("ab_busy_before", 32'(busy), 1);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy_drop", 32'(busy), 0);
        check("ab_ready", 32'(cfg_ready), 1);
        do_cfg(16'd40, 4'b0001, 8'd0, 8'd255, 1'b0);
        check("ab_new_busy", 32'(busy), 1);
        wait_v(100, n);
        check("ab_latency", n, S + 40);
        check_rng("ab_ch0", 32'(chan(0)), 9, 11);
        check("ab_masked", {8'd0, count[31:8]}, 0);
        pulse_yumi();

        // W=0 with a stopped clock on channel 0, lo=1
        mon_half[0] = 0;
        repeat (6) @(negedge clk);
        do_cfg(16'd0, 4'b0001, 8'd1, 8'd255, 1'b0);
        wait_v(20, n);
        check("w0_latency", n, S + 1);
        check("w0_count", count, 0);
        check("w0_oor", 32'(oor), 32'h1);
        check("w0_ovf", 32'(ovf), 0);
        pulse_yumi();

        // Asynchronous reset mid-MEASURE
        mon_half[0] = 20;
        do_cfg(16'd200, 4'b1111, 8'd0, 8'd255, 1'b0);
        repeat (20) @(negedge clk);
        check("rr_busy_before", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rr_busy", 32'(busy), 0);
        check("rr_ready", 32'(cfg_ready), 1);
        check("rr_v", 32'(v), 0);
        check("rr_oor", 32'(oor), 0);
        check("rr_count_ovf", {28'd0, ovf} | count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rr_ready_after", 32'(cfg_ready), 1);
        check("rr_busy_after", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
